arbitro_memoria_32bits: RTL
===========================

Name: arbitro_memoria_32bits

Overview:
- Sequences one shared single-port 32-bit memory between two requesters: requester 0 (instruction fetch) and requester 1 (data load/store).
- Arbitrates between them, captures the winner's request, and drives the select of the 32-bit 2:1 address/data mux in front of the memory.
- Holds the memory for a fixed latency, then returns read data with a one-cycle ack.
- Sits between the fetch/memory-stage logic and the memory model.

Parameters:
- MEM_LAT, 2, memory access latency in cycles, 1..15; mem_rdata is valid in the last BUSY cycle.
- PRIO_FIJA, 0, 0 = round-robin on ties; 1 = requester 0 always wins ties.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 request; level, held until ack0
- addr0  in  32  requester 0 address
- wdata0  in  32  requester 0 write data
- we0  in  1  requester 0 write enable
- ack0  out  1  one-cycle completion pulse to requester 0
- rdata0  out  32  read data for requester 0; valid while ack0=1
- req1, addr1, wdata1, we1, ack1, rdata1: same as the requester 0 ports, for requester 1
- sel  out  1  mux select: 0 = requester 0 path, 1 = requester 1 path
- mem_en  out  1  memory enable, high for exactly MEM_LAT cycles per transaction
- mem_we  out  1  memory write enable; captured we of the winner, gated by mem_en
- mem_addr  out  32  captured address
- mem_wdata  out  32  captured write data
- mem_rdata  in  32  memory read data
- busy  out  1  high in BUSY and DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, cnt=0, last_grant=1, so requester 0 wins the first tie. All outputs are 0: sel, mem_en, mem_we, mem_addr, mem_wdata, ack0, ack1, rdata0, rdata1, busy.
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE with no req: stay in IDLE.
- IDLE with any req: choose the winner.
  - Only one req is high: that requester wins.
  - Both high, PRIO_FIJA=1: requester 0 wins.
  - Both high, PRIO_FIJA=0: the requester that is not last_grant wins.
  - On the clock edge: capture the winner's addr/wdata/we into mem_addr/mem_wdata/mem_we, set sel=winner, set last_grant=winner, cnt=0, mem_en=1, go to BUSY.
- BUSY: mem_en=1. cnt increments each cycle. In the cycle where cnt==MEM_LAT-1:
  - capture mem_rdata into the winner's rdata register;
  - set the winner's ack=1;
  - clear mem_en and mem_we;
  - go to DONE.
- DONE: the winner's ack is high for exactly this one cycle, then cleared. Next state is IDLE. sel and mem_addr hold their values until the next grant.
- Latency: req sampled in IDLE at cycle T gives mem_en during T+1..T+MEM_LAT and ack at T+MEM_LAT+1. Minimum spacing between grants is MEM_LAT+2 cycles.
- rdata of the non-winner is unchanged. Write transactions still pulse ack; rdata then holds whatever mem_rdata showed, and the requester ignores it.
- req is sampled only in IDLE:
  - Deasserting req during BUSY does not abort the transaction; it completes and acks.
  - A requester that keeps req high through the cycle after ack is treated as making a new request.
- The loser's req stays pending and is served in the next IDLE. Under PRIO_FIJA=0, two always-high requesters alternate 0,1,0,1.
- Captured fields are stable for the whole transaction regardless of input changes.
- rst asserted mid-transaction: immediate return to reset values. No ack is issued, and mem_en drops asynchronously.
- cnt width is 4 bits. MEM_LAT outside 1..15 is illegal and is flagged by an elaboration-time check.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2;
  - the SEL_REQ0=1'b0 and SEL_REQ1=1'b1 constants;
  - the maximum-latency constant 15.
- One natural sub-module: arbitro_rr_2, a combinational 2-way tie-break taking req0, req1, last_grant and PRIO_FIJA and returning the winner. The capture registers, counter and FSM stay in the top module.

Test Plan:
1. Reset, then req0=1, addr0=32'h0000_0040, we0=0, MEM_LAT=2, memory returns 32'h2002_0005 -> mem_en high 2 cycles, sel=0, mem_addr=32'h40, ack0 one cycle later with rdata0=32'h2002_0005; ack1 stays 0.
2. req1=1, we1=1, addr1=32'h1000_0004, wdata1=32'hDEAD_BEEF -> sel=1, mem_we=1 and mem_wdata=32'hDEAD_BEEF for 2 cycles, ack1 pulses, rdata0 unchanged.
3. req0 and req1 both held high, PRIO_FIJA=0 -> grant order 0,1,0,1 with ack spacing of 4 cycles. With PRIO_FIJA=1 -> only requester 0 is served while req0 stays high.
4. Grant requester 0 with addr0=32'h80, then change addr0 to 32'hFC and drop req0 in the first BUSY cycle -> mem_addr stays 32'h80 and ack0 still pulses.
5. Assert rst in the second BUSY cycle -> mem_en, sel, busy and the acks go to 0 without waiting for a clock edge. After release, no ack arrives until a new req.
6. MEM_LAT=1 with back-to-back req0 -> mem_en high 1 cycle, ack 2 cycles after the sampling IDLE cycle, next grant 3 cycles after the previous one.

Source files
------------

// File: rtl/arbitro_memoria_32bits_pkg.sv
// Shared definitions for the two-requester single-port memory sequencer:
// FSM encodings, mux-select values and counter sizing.
package arbitro_memoria_32bits_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic SEL_REQ0 = 1'b0;
    localparam logic SEL_REQ1 = 1'b1;

    localparam int MAX_LAT = 15;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/arbitro_memoria_32bits_rr_2.sv
// Two-way tie-break: picks the requester that gets the memory next.
// Round-robin against last_grant, or fixed priority to requester 0.
module arbitro_rr_2
    import arbitro_memoria_32bits_pkg::*;
#(
    parameter int PRIO_FIJA = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic any_req,
    output logic winner
);

    // NOTE: every output gets a default first so no path through the block
    // leaves it unassigned; that is what keeps this purely combinational.
    always_comb begin
        any_req = req0 | req1;
        winner  = SEL_REQ0;
        if (req0 && req1) begin
            winner = (PRIO_FIJA != 0) ? SEL_REQ0 : ~last_grant;
        end else if (req1) begin
            winner = SEL_REQ1;
        end
    end

endmodule

// File: rtl/arbitro_memoria_32bits.sv
// Sequences a shared single-port 32-bit memory between instruction fetch
// (requester 0) and data load/store (requester 1); all outputs registered.
module arbitro_memoria_32bits
    import arbitro_memoria_32bits_pkg::*;
#(
    parameter int MEM_LAT   = 2,
    parameter int PRIO_FIJA = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        we0,
    output logic        ack0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        we1,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        sel,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    if (MEM_LAT < 1 || MEM_LAT > MAX_LAT) begin : g_bad_mem_lat
        $error("arbitro_memoria_32bits: MEM_LAT=%0d outside 1..%0d", MEM_LAT, MAX_LAT);
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              sel_q, sel_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;
    logic              busy_q, busy_d;

    logic any_req;
    logic winner;

    arbitro_rr_2 #(
        .PRIO_FIJA (PRIO_FIJA)
    ) u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .any_req    (any_req),
        .winner     (winner)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        busy_d       = busy_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    sel_d        = winner;
                    last_grant_d = winner;
                    mem_addr_d   = (winner == SEL_REQ1) ? addr1  : addr0;
                    mem_wdata_d  = (winner == SEL_REQ1) ? wdata1 : wdata0;
                    mem_we_d     = (winner == SEL_REQ1) ? we1    : we0;
                    mem_en_d     = 1'b1;
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_BUSY;
                end
            end

            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // mem_rdata is valid in the last access cycle; capture it there.
                if (cnt_q == CNT_LAST) begin
                    if (sel_q == SEL_REQ1) begin
                        rdata1_d = mem_rdata;
                        ack1_d   = 1'b1;
                    end else begin
                        rdata0_d = mem_rdata;
                        ack0_d   = 1'b1;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= SEL_REQ1;
            sel_q        <= SEL_REQ0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign sel       = sel_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign busy      = busy_q;

endmodule
